demux_6_stream: RTL and testbench
=================================

DEMUX_6_STREAM -- requirements
Module: demux_6_stream

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, which sets the width of every data path.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1 bit: the reset, synchronous and active-low.
REQ-004 Port in_valid, input, 1 bit: the upstream word on in_data/in_sel is valid.
REQ-005 Port in_ready, output, 1 bit: the block accepts the upstream word this cycle.
REQ-006 Port in_data, input, DATA_WIDTH bits: the upstream payload.
REQ-007 Port in_sel, input, 3 bits: the destination channel; 0..5 are legal, 6 and 7 are illegal.
REQ-008 Port out_valid, output, 6 bits: bit k means channel k holds a valid word.
REQ-009 Port out_ready, input, 6 bits: bit k means the channel k consumer takes the word this cycle.
REQ-010 Port out_data, output, 6*DATA_WIDTH bits: channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 Port drop_cnt, output, 8 bits: saturating count of words dropped because in_sel was illegal.
REQ-012 Port drop_flag, output, 1 bit: sticky; set on the first dropped word.

Function
REQ-013 An input transfer SHALL occur when in_valid and in_ready are both 1 at a rising clk edge; an output transfer on channel k SHALL occur when out_valid[k] and out_ready[k] are both 1.
REQ-014 Each channel SHALL have exactly one holding register, consisting of the data slice plus out_valid[k].
REQ-015 in_ready SHALL be combinational: 1 if in_sel is 6 or 7; otherwise (~out_valid[in_sel] | out_ready[in_sel]).
REQ-016 in_ready SHALL NOT depend on in_valid.
REQ-017 On an input transfer with in_sel = k (k = 0..5), the data slice of channel k SHALL load in_data and out_valid[k] SHALL be 1 in the next cycle; latency is 1 cycle.
REQ-018 An input transfer with in_sel = k SHALL NOT change any channel other than k.
REQ-019 When channel k has an output transfer and no input transfer targets it in the same cycle, out_valid[k] SHALL go to 0 next cycle and its data slice SHALL keep its old value.
REQ-020 When channel k has an output transfer and an input transfer targets it in the same cycle, the new word SHALL load and out_valid[k] SHALL stay 1; this gives one word per cycle of sustained throughput on a channel.
REQ-021 While out_valid[k] = 1 and out_ready[k] = 0, the data slice of channel k SHALL be held stable.
REQ-022 Channels SHALL drain independently; a stall on one channel SHALL block only input words addressed to that channel.
REQ-023 Word order SHALL be preserved within each channel.
REQ-024 On an input transfer with in_sel = 6 or 7, the word SHALL be discarded and no channel state SHALL change.
REQ-025 On the same illegal-select transfer, drop_cnt SHALL increment by 1, saturating at 255.
REQ-026 On the same illegal-select transfer, drop_flag SHALL be set to 1.
REQ-027 drop_flag SHALL be cleared only by reset.
REQ-028 When in_valid = 0, no state SHALL change other than output-transfer effects.

Reset
REQ-029 When rst_n = 0 at a rising clk edge, the next state SHALL be: out_valid = 0, all out_data slices = 0, drop_cnt = 0, drop_flag = 0.
REQ-030 Reset SHALL take priority over any concurrent input or output transfer.
REQ-031 Words held at reset SHALL be lost.
REQ-032 During reset, in_ready SHALL still follow REQ-015 on the reset register values, so in_ready = 1.
REQ-033 No transfer SHALL take effect in a cycle in which rst_n = 0.

Verification
REQ-034 Scenario, single word: with all out_ready = 0, send in_sel = 3, in_data = 0xDEADBEEF -> next cycle out_valid = 6'b001000 and slice 3 = 0xDEADBEEF; a second word to channel 3 sees in_ready = 0.
REQ-035 Scenario, streaming: hold out_ready[2] = 1 and send 8 back-to-back words 1..8 with in_sel = 2 -> in_ready stays 1 throughout, channel 2 delivers 1..8 in order, one per cycle, and out_valid[2] drops one cycle after the last word.
REQ-036 Scenario, independent stall: fill channel 0 with out_ready[0] = 0, then send to channel 5 -> channel 5 word delivered; channel 0 word unchanged.
REQ-037 Scenario, illegal select: send 300 words with in_sel = 7 -> in_ready = 1 for every one, out_valid stays 0, drop_cnt = 255, drop_flag = 1.
REQ-038 Scenario, reset mid-operation: with channels 1 and 4 full, drop_cnt = 5, and an input transfer pending, assert rst_n = 0 for one cycle -> out_valid = 0, out_data = 0, drop_cnt = 0, drop_flag = 0, and the pending word is not captured.
REQ-039 Scenario, simultaneous push and pop: channel 4 holds 0xA, out_ready[4] = 1, and 0xB arrives with in_sel = 4 in the same cycle -> next cycle slice 4 = 0xB and out_valid[4] = 1.

Source files
------------

// File: rtl/demux_6_stream.sv
// demux_6_stream: routes one upstream stream to six output channels.
// Each channel has a single holding register (data + valid) with a
// skid-free ready: a full channel still accepts a word in the cycle it
// is being drained. Illegal selects (6, 7) are accepted and dropped.
// A saturating counter and a sticky flag record the drops.
module demux_6_stream #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [2:0]              in_sel,
    output logic [5:0]              out_valid,
    input  logic [5:0]              out_ready,
    output logic [6*DATA_WIDTH-1:0] out_data,
    output logic [7:0]              drop_cnt,
    output logic                    drop_flag
);

    localparam int         NUM_CH  = 6;
    localparam logic [7:0] CNT_MAX = 8'hFF;

    // True when the select addresses an existing channel.
    function automatic logic sel_legal(input logic [2:0] sel);
        return sel < 3'(NUM_CH);
    endfunction

    // Increment that sticks at the counter's maximum value.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == CNT_MAX) ? value : value + 8'd1;
    endfunction

    logic [DATA_WIDTH-1:0] slot_data [NUM_CH];
    logic [NUM_CH-1:0]     slot_valid;
    logic [NUM_CH-1:0]     push;
    logic [NUM_CH-1:0]     pop;
    logic                  in_fire;
    logic                  drop_fire;

    // Ready looks only at the addressed slot: empty or draining this cycle.
    // Illegal selects are always accepted so they never stall the source.
    always_comb begin
        in_ready = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (in_sel == 3'(k)) begin
                in_ready = ~slot_valid[k] | out_ready[k];
            end
        end
    end

    assign in_fire   = in_valid & in_ready;
    assign drop_fire = in_fire & ~sel_legal(in_sel);

    // Per-channel load and drain strobes.
    always_comb begin
        push = '0;
        pop  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            push[k] = in_fire & (in_sel == 3'(k));
            pop[k]  = slot_valid[k] & out_ready[k];
        end
    end

    // Holding registers: a load wins over a drain so a channel can stream
    // one word per cycle; a drain alone clears valid but keeps the data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_valid <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                slot_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (push[k]) begin
                    slot_data[k]  <= in_data;
                    slot_valid[k] <= 1'b1;
                end else if (pop[k]) begin
                    slot_valid[k] <= 1'b0;
                end
            end
        end
    end

    // Drop bookkeeping for words carrying an illegal select.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt  <= 8'd0;
            drop_flag <= 1'b0;
        end else if (drop_fire) begin
            drop_cnt  <= sat_inc(drop_cnt);
            drop_flag <= 1'b1;
        end
    end

    // Flatten the per-channel slots onto the output bus.
    always_comb begin
        out_valid = slot_valid;
        out_data  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            out_data[k*DATA_WIDTH +: DATA_WIDTH] = slot_data[k];
        end
    end

endmodule

// File: tb/tb_demux_6_stream.sv
// Bench for demux_6_stream: directed scenarios plus a random phase, with a
// per-channel queue scoreboard checked every cycle by an independent monitor.
module tb_demux_6_stream;

    localparam int DW  = 32;
    localparam int NCH = 6;

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b0;
    logic            in_valid  = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   in_data   = '0;
    logic [2:0]      in_sel    = '0;
    logic [5:0]      out_valid;
    logic [5:0]      out_ready = '0;
    logic [6*DW-1:0] out_data;
    logic [7:0]      drop_cnt;
    logic            drop_flag;

    demux_6_stream #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .drop_cnt  (drop_cnt),
        .drop_flag (drop_flag)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef logic [DW-1:0] word_q_t [$];
    word_q_t       sb_q [NCH];
    logic [DW-1:0] mdl_slice [NCH];
    int            mdl_drops = 0;
    logic          mdl_flag  = 1'b0;
    bit            armed     = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT against the queue model, then apply this cycle's transfers.
    always @(negedge clk) begin
        logic          exp_rdy;
        int            s;
        logic [DW-1:0] word;
        s = int'(in_sel);
        exp_rdy = 1'b1;
        if (s < NCH) exp_rdy = (sb_q[s].size() == 0) || out_ready[s];
        if (armed) begin
            for (int k = 0; k < NCH; k++) begin
                check($sformatf("out_valid[%0d]", k), DW'(out_valid[k]), DW'(sb_q[k].size() != 0));
                check($sformatf("slice[%0d]", k), out_data[k*DW +: DW], mdl_slice[k]);
            end
            check("in_ready", DW'(in_ready), DW'(exp_rdy));
            check("drop_cnt", DW'(drop_cnt), DW'(mdl_drops));
            check("drop_flag", DW'(drop_flag), DW'(mdl_flag));
        end
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                sb_q[k].delete();
                mdl_slice[k] = '0;
            end
            mdl_drops = 0;
            mdl_flag  = 1'b0;
            armed     = 1'b1;
        end else if (armed) begin
            for (int k = 0; k < NCH; k++) begin
                if (sb_q[k].size() != 0 && out_ready[k]) begin
                    word = sb_q[k].pop_front();
                    check($sformatf("pop ch%0d", k), out_data[k*DW +: DW], word);
                end
            end
            if (in_valid && exp_rdy) begin
                if (s < NCH) begin
                    sb_q[s].push_back(in_data);
                    mdl_slice[s] = in_data;
                end else begin
                    if (mdl_drops < 255) mdl_drops++;
                    mdl_flag = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until accepted; returns 1 unit after the transfer edge.
    task automatic send(input logic [2:0] sel, input logic [DW-1:0] data);
        int n;
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout: sel %0d never accepted, got ready 0 expected 1", sel);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst out_valid", DW'(out_valid), 0);
        check("rst out_data zero", DW'(out_data == '0), 1);
        check("rst drop_cnt", DW'(drop_cnt), 0);
        check("rst in_ready", DW'(in_ready), 1);

        // Single word to channel 3, then a blocked second word
        out_ready = '0;
        send(3'd3, 32'hDEADBEEF);
        check("single out_valid", DW'(out_valid), DW'(6'b001000));
        check("single slice3", out_data[3*DW +: DW], 32'hDEADBEEF);
        in_valid = 1'b1;
        in_sel   = 3'd3;
        in_data  = 32'h12345678;
        @(negedge clk);
        check("single blocked ready", DW'(in_ready), 0);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        check("single still first", out_data[3*DW +: DW], 32'hDEADBEEF);
        out_ready = 6'b001000;
        tick();
        out_ready = '0;

        // Streaming 1..8 into channel 2 with the consumer always ready
        out_ready = 6'b000100;
        for (int i = 1; i <= 8; i++) send(3'd2, DW'(i));
        check("stream last valid", DW'(out_valid[2]), 1);
        check("stream last data", out_data[2*DW +: DW], 8);
        tick();
        check("stream valid drops", DW'(out_valid[2]), 0);
        out_ready = '0;

        // Stalled channel 0 must not block channel 5
        send(3'd0, 32'h0000_1111);
        send(3'd5, 32'h0000_5555);
        out_ready = 6'b100000;
        tick();
        check("indep out_valid", DW'(out_valid), DW'(6'b000001));
        check("indep slice0", out_data[0 +: DW], 32'h0000_1111);
        check("indep slice5 kept", out_data[5*DW +: DW], 32'h0000_5555);
        out_ready = 6'b000001;
        tick();
        out_ready = '0;

        // 300 illegal-select words saturate the drop counter
        for (int i = 0; i < 300; i++) send(3'($urandom_range(7, 6)), $urandom);
        check("illegal drop_cnt", DW'(drop_cnt), 255);
        check("illegal drop_flag", DW'(drop_flag), 1);
        check("illegal out_valid", DW'(out_valid), 0);

        // Reset in the middle of traffic
        pulse_reset();
        for (int i = 0; i < 5; i++) send(3'd6, $urandom);
        send(3'd1, 32'hA1A1_A1A1);
        send(3'd4, 32'hA4A4_A4A4);
        check("mid drop_cnt", DW'(drop_cnt), 5);
        check("mid out_valid", DW'(out_valid), DW'(6'b010010));
        in_valid = 1'b1;
        in_sel   = 3'd2;
        in_data  = 32'hBAD0_0002;
        pulse_reset();
        in_valid = 1'b0;
        check("mid rst out_valid", DW'(out_valid), 0);
        check("mid rst out_data", DW'(out_data == '0), 1);
        check("mid rst drop_cnt", DW'(drop_cnt), 0);
        check("mid rst drop_flag", DW'(drop_flag), 0);
        tick();
        check("mid pending lost", DW'(out_valid), 0);

        // Simultaneous push and pop on channel 4
        send(3'd4, 32'h0000_000A);
        out_ready = 6'b010000;
        in_valid  = 1'b1;
        in_sel    = 3'd4;
        in_data   = 32'h0000_000B;
        tick();
        in_valid  = 1'b0;
        out_ready = '0;
        check("pushpop valid", DW'(out_valid[4]), 1);
        check("pushpop slice4", out_data[4*DW +: DW], 32'h0000_000B);
        out_ready = 6'b010000;
        tick();
        out_ready = '0;

        // Random traffic
        pulse_reset();
        for (int i = 0; i < 2000; i++) begin
            in_valid  = 1'($urandom_range(1, 0));
            in_sel    = ($urandom_range(9, 0) == 0) ? 3'($urandom_range(7, 6)) : 3'($urandom_range(5, 0));
            in_data   = $urandom;
            out_ready = 6'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = '1;
        repeat (3) tick();
        check("final drained", DW'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
